// File: rtl/tc_multi_if.sv
// Register bus shared by the memory-mapped peripherals: single-cycle write,
// combinational read data selected by the word address.
interface tc_multi_if #(
    parameter int ADDR_W = 6
) ();
    logic              we_i;
    logic [ADDR_W-1:0] add_i;
    logic [31:0]       dat_i;
    logic [31:0]       dat_o;

    modport master (output we_i, add_i, dat_i, input dat_o);
    modport slave  (input we_i, add_i, dat_i, output dat_o);
endinterface

// File: rtl/tc_multi.sv
// Multi-channel down-counting timer with per-channel prescaler, one-shot,
// free-running and periodic-interrupt modes, and W1C pending flags.
module tc_multi #(
    parameter int NCH    = 4,
    parameter int CNT_W  = 32,
    parameter int PSC_W  = 8,
    parameter int ADDR_W = 6
) (
    input  logic           clk_i,
    input  logic           rst_i,
    tc_multi_if.slave      bus,
    output logic [NCH-1:0] irq_o,
    output logic           irq
);

    logic             r_en     [NCH];
    logic [1:0]       r_mode   [NCH];
    logic             r_im     [NCH];
    logic [PSC_W-1:0] r_psc    [NCH];
    logic [CNT_W-1:0] r_preset [NCH];
    logic [CNT_W-1:0] r_count  [NCH];
    logic             r_pend   [NCH];
    logic [PSC_W-1:0] r_pcnt   [NCH];

    logic [31:0] w_ch;
    logic [1:0]  w_reg;
    logic [1:0]  w_newMode;
    logic        w_sel  [NCH];
    logic        w_tick [NCH];
    logic [31:0] w_rdata;
    logic        w_unusedDat;

    // The channel field is compared at full width so any index >= NCH selects nothing.
    assign w_ch        = 32'(bus.add_i) >> 2;
    assign w_reg       = bus.add_i[1:0];
    assign w_newMode   = (bus.dat_i[2:1] == 2'b11) ? 2'b00 : bus.dat_i[2:1];
    assign w_unusedDat = ^bus.dat_i;

    always_comb begin
        for (int n = 0; n < NCH; n++) begin
            w_sel[n]  = (w_ch == n);
            w_tick[n] = r_en[n] && (r_pcnt[n] == r_psc[n]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int n = 0; n < NCH; n++) begin
                r_en[n]     <= 1'b0;
                r_mode[n]   <= 2'd0;
                r_im[n]     <= 1'b0;
                r_psc[n]    <= '0;
                r_preset[n] <= '0;
                r_count[n]  <= '0;
                r_pend[n]   <= 1'b0;
                r_pcnt[n]   <= '0;
            end
        end else begin
            for (int n = 0; n < NCH; n++) begin
                if (bus.we_i && w_sel[n] && (w_reg == 2'd0)) begin
                    // A CTRL write swallows any tick due this cycle.
                    r_mode[n] <= w_newMode;
                    r_im[n]   <= bus.dat_i[3];
                    r_psc[n]  <= bus.dat_i[8 +: PSC_W];
                    if (!bus.dat_i[0]) begin
                        r_en[n] <= 1'b0;
                    end else if (!r_en[n]) begin
                        r_en[n]    <= 1'b1;
                        r_count[n] <= r_preset[n];
                        r_pcnt[n]  <= '0;
                        r_pend[n]  <= 1'b0;
                    end
                end else begin
                    if (bus.we_i && w_sel[n] && (w_reg == 2'd1))
                        r_preset[n] <= bus.dat_i[CNT_W-1:0];
                    if (bus.we_i && w_sel[n] && (w_reg == 2'd3) && bus.dat_i[0])
                        r_pend[n] <= 1'b0;
                    // Later pend sets override the W1C above, so a set wins a same-cycle clear.
                    if (r_en[n]) begin
                        if (w_tick[n]) begin
                            r_pcnt[n] <= '0;
                            if (r_count[n] > CNT_W'(1)) begin
                                r_count[n] <= r_count[n] - CNT_W'(1);
                            end else if (r_count[n] == CNT_W'(1)) begin
                                r_count[n] <= '0;
                                if (r_mode[n] == 2'd0) begin
                                    r_en[n]   <= 1'b0;
                                    r_pend[n] <= 1'b1;
                                end else if (r_mode[n] == 2'd2) begin
                                    r_pend[n] <= 1'b1;
                                end
                            end else if (r_mode[n] == 2'd0) begin
                                r_en[n]   <= 1'b0;
                                r_pend[n] <= 1'b1;
                            end else begin
                                r_count[n] <= r_preset[n];
                                if ((r_mode[n] == 2'd2) && (r_preset[n] == '0))
                                    r_pend[n] <= 1'b1;
                            end
                        end else begin
                            r_pcnt[n] <= r_pcnt[n] + PSC_W'(1);
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        for (int n = 0; n < NCH; n++) begin
            if (w_sel[n]) begin
                case (w_reg)
                    2'd0: begin
                        w_rdata[0]          = r_en[n];
                        w_rdata[2:1]        = r_mode[n];
                        w_rdata[3]          = r_im[n];
                        w_rdata[8 +: PSC_W] = r_psc[n];
                    end
                    2'd1:    w_rdata = 32'(r_preset[n]);
                    2'd2:    w_rdata = 32'(r_count[n]);
                    default: w_rdata[1:0] = {r_en[n], r_pend[n]};
                endcase
            end
        end
    end

    assign bus.dat_o = w_rdata;

    always_comb begin
        irq_o = '0;
        for (int n = 0; n < NCH; n++) irq_o[n] = r_pend[n] & r_im[n];
    end

    assign irq = |irq_o;

endmodule

// File: tb/tb_tc_multi.sv
// Bench for tc_multi: constant vector table, hand-built multi-cycle sequences,
// and a randomized run against a rule-level model of the channels.
module tb_tc_multi;
    localparam int NCH    = 4;
    localparam int CNT_W  = 32;
    localparam int PSC_W  = 8;
    localparam int ADDR_W = 6;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic [NCH-1:0] irq_o;
    logic           irq;

    tc_multi_if #(.ADDR_W(ADDR_W)) bus ();

    tc_multi #(.NCH(NCH), .CNT_W(CNT_W), .PSC_W(PSC_W), .ADDR_W(ADDR_W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave),
        .irq_o (irq_o),
        .irq   (irq)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          en;
        int          mode;
        bit          im;
        int          psc;
        logic [31:0] preset;
        logic [31:0] count;
        bit          pend;
        int          pcnt;
    } chan_t;

    chan_t m [NCH];

    function automatic chan_t zeroChan();
        chan_t z;
        z.en = 0; z.mode = 0; z.im = 0; z.psc = 0;
        z.preset = '0; z.count = '0; z.pend = 0; z.pcnt = 0;
        return z;
    endfunction

    // One clock of every channel, applying the register rules to the pre-edge state.
    function automatic void modelStep(bit rst, bit we, logic [5:0] addr, logic [31:0] data);
        for (int c = 0; c < NCH; c++) begin
            chan_t o;
            chan_t n;
            bit    hit;
            int    r;
            int    md;
            o   = m[c];
            n   = m[c];
            hit = we && (int'(addr[5:2]) == c);
            r   = int'(addr[1:0]);
            if (rst) begin
                n = zeroChan();
            end else if (hit && r == 0) begin
                md = int'(data[2:1]);
                n.mode = (md == 3) ? 0 : md;
                n.im   = data[3];
                n.psc  = int'(data[15:8]);
                if (!data[0]) n.en = 0;
                else if (!o.en) begin
                    n.en = 1; n.count = o.preset; n.pcnt = 0; n.pend = 0;
                end
            end else begin
                if (hit && r == 1) n.preset = data;
                if (hit && r == 3 && data[0]) n.pend = 0;
                if (o.en) begin
                    if (o.pcnt != o.psc) begin
                        n.pcnt = (o.pcnt + 1) % 256;
                    end else begin
                        n.pcnt = 0;
                        if (o.count > 1) n.count = o.count - 1;
                        else if (o.count == 1) begin
                            n.count = 0;
                            if (o.mode == 0) begin n.en = 0; n.pend = 1; end
                            if (o.mode == 2) n.pend = 1;
                        end else if (o.mode == 0) begin
                            n.en = 0; n.pend = 1;
                        end else begin
                            n.count = o.preset;
                            if (o.mode == 2 && o.preset == 0) n.pend = 1;
                        end
                    end
                end
            end
            m[c] = n;
        end
    endfunction

    function automatic logic [31:0] modelRead(logic [5:0] addr);
        int c;
        c = int'(addr[5:2]);
        if (c >= NCH) return 32'h0;
        case (addr[1:0])
            2'd0:    return (32'(m[c].psc) << 8) | (32'(m[c].im) << 3) |
                            (32'(m[c].mode) << 1) | 32'(m[c].en);
            2'd1:    return m[c].preset;
            2'd2:    return m[c].count;
            default: return (32'(m[c].en) << 1) | 32'(m[c].pend);
        endcase
    endfunction

    function automatic logic [NCH-1:0] modelIrq();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = m[c].pend & m[c].im;
        return v;
    endfunction

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(bit rst, bit we, logic [5:0] addr, logic [31:0] data);
        rst_i      = rst;
        bus.we_i   = we;
        bus.add_i  = addr;
        bus.dat_i  = data;
        @(posedge clk_i);
        modelStep(rst, we, addr, data);
        #1;
        rst_i    = 1'b0;
        bus.we_i = 1'b0;
    endtask

    task automatic checkRead(string name, logic [5:0] addr, logic [31:0] exp);
        bus.add_i = addr;
        #1;
        checkOutput(name, bus.dat_o, exp);
    endtask

    typedef struct {
        bit             we;
        logic [5:0]     addr;
        logic [31:0]    data;
        logic [5:0]     rdAddr;
        logic [31:0]    expRd;
        logic [NCH-1:0] expIrq;
    } vec_t;

    vec_t tbl [19];

    int          cntExp2 [6] = '{2, 1, 0, 2, 1, 0};
    int          cntExp3 [9] = '{1, 1, 0, 0, 0, 1, 1, 1, 0};
    bit          pendExp3 [9] = '{0, 0, 1, 0, 0, 0, 0, 0, 1};

    initial begin
        tbl[0]  = '{1'b1, 6'd0,  32'h1234_5678, 6'd0,  32'h0000_5608, 4'b0000};
        tbl[1]  = '{1'b0, 6'd0,  32'h0,         6'd1,  32'h0,         4'b0000};
        tbl[2]  = '{1'b0, 6'd0,  32'h0,         6'd2,  32'h0,         4'b0000};
        tbl[3]  = '{1'b0, 6'd0,  32'h0,         6'd3,  32'h0,         4'b0000};
        tbl[4]  = '{1'b1, 6'd5,  32'd3,         6'd5,  32'd3,         4'b0000};
        tbl[5]  = '{1'b1, 6'd4,  32'h9,         6'd6,  32'd3,         4'b0000};
        tbl[6]  = '{1'b0, 6'd0,  32'h0,         6'd6,  32'd2,         4'b0000};
        tbl[7]  = '{1'b0, 6'd0,  32'h0,         6'd6,  32'd1,         4'b0000};
        tbl[8]  = '{1'b0, 6'd0,  32'h0,         6'd7,  32'h1,         4'b0010};
        tbl[9]  = '{1'b0, 6'd0,  32'h0,         6'd6,  32'd0,         4'b0010};
        tbl[10] = '{1'b0, 6'd0,  32'h0,         6'd7,  32'h1,         4'b0010};
        tbl[11] = '{1'b1, 6'd7,  32'h1,         6'd7,  32'h0,         4'b0000};
        tbl[12] = '{1'b1, 6'd16, 32'hFFFF_FFFF, 6'd16, 32'h0,         4'b0000};
        tbl[13] = '{1'b1, 6'd17, 32'h0000_FFFF, 6'd17, 32'h0,         4'b0000};
        tbl[14] = '{1'b0, 6'd0,  32'h0,         6'd5,  32'd3,         4'b0000};
        tbl[15] = '{1'b0, 6'd0,  32'h0,         6'd1,  32'h0,         4'b0000};
        tbl[16] = '{1'b0, 6'd0,  32'h0,         6'd0,  32'h0000_5608, 4'b0000};
        tbl[17] = '{1'b1, 6'd6,  32'h55,        6'd6,  32'h0,         4'b0000};
        tbl[18] = '{1'b1, 6'd8,  32'h6,         6'd8,  32'h0,         4'b0000};

        rst_i = 1'b1; bus.we_i = 1'b0; bus.add_i = '0; bus.dat_i = '0;
        for (int c = 0; c < NCH; c++) m[c] = zeroChan();
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("reset irq_o", 32'(irq_o), 32'h0);
        checkOutput("reset irq", 32'(irq), 32'h0);

        // Constant vectors: CTRL masking, one-shot expiry, W1C, out-of-range, read-only COUNT.
        for (int i = 0; i < 19; i++) begin
            applyStimulus(0, tbl[i].we, tbl[i].addr, tbl[i].data);
            checkOutput($sformatf("vec%0d irq_o", i), 32'(irq_o), 32'(tbl[i].expIrq));
            checkOutput($sformatf("vec%0d irq", i), 32'(irq), 32'(|tbl[i].expIrq));
            checkRead($sformatf("vec%0d rd@%0d", i, tbl[i].rdAddr), tbl[i].rdAddr, tbl[i].expRd);
        end

        // Ch2 free-running reload, no pending flag.
        applyStimulus(0, 1, 6'd9, 32'd2);
        applyStimulus(0, 1, 6'd8, 32'h3);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) applyStimulus(0, 0, 0, 0);
            checkRead($sformatf("ch2 count step%0d", i), 6'd10, 32'(cntExp2[i]));
            checkRead($sformatf("ch2 status step%0d", i), 6'd11, 32'h2);
            checkOutput($sformatf("ch2 irq step%0d", i), 32'(irq_o[2]), 32'h0);
        end
        applyStimulus(0, 1, 6'd8, 32'h0);

        // Ch3 periodic with prescaler 2; W1C alone clears, W1C against a set loses.
        applyStimulus(0, 1, 6'd13, 32'd1);
        applyStimulus(0, 1, 6'd12, 32'h20D);
        checkRead("ch3 count start", 6'd14, 32'd1);
        for (int k = 0; k < 9; k++) begin
            if (k == 3 || k == 8) applyStimulus(0, 1, 6'd15, 32'h1);
            else applyStimulus(0, 0, 0, 0);
            checkRead($sformatf("ch3 count k%0d", k + 1), 6'd14, 32'(cntExp3[k]));
            checkRead($sformatf("ch3 status k%0d", k + 1), 6'd15, 32'h2 | 32'(pendExp3[k]));
            checkOutput($sformatf("ch3 irq k%0d", k + 1), 32'(irq_o[3]), 32'(pendExp3[k]));
        end
        applyStimulus(0, 1, 6'd12, 32'h204);
        checkOutput("ch3 irq masked", 32'(irq_o[3]), 32'h0);
        checkRead("ch3 pend held while stopped", 6'd15, 32'h1);
        applyStimulus(0, 1, 6'd12, 32'h20C);
        checkOutput("ch3 irq unmasked", 32'(irq_o[3]), 32'h1);
        checkOutput("irq or", 32'(irq), 32'h1);

        // Ch0 one-shot from 100: stop at 60, restart with new preset, then reset mid-count.
        applyStimulus(0, 1, 6'd1, 32'd100);
        applyStimulus(0, 1, 6'd0, 32'h9);
        checkRead("ch0 count start", 6'd2, 32'd100);
        repeat (40) applyStimulus(0, 0, 0, 0);
        checkRead("ch0 count at 60", 6'd2, 32'd60);
        applyStimulus(0, 1, 6'd0, 32'h8);
        checkRead("ch0 count after stop", 6'd2, 32'd60);
        repeat (3) applyStimulus(0, 0, 0, 0);
        checkRead("ch0 count held", 6'd2, 32'd60);
        checkRead("ch0 status stopped", 6'd3, 32'h0);
        applyStimulus(0, 1, 6'd1, 32'd5);
        checkRead("ch0 count after preset write", 6'd2, 32'd60);
        applyStimulus(0, 1, 6'd0, 32'h9);
        checkRead("ch0 count restart", 6'd2, 32'd5);
        repeat (2) applyStimulus(0, 0, 0, 0);
        checkRead("ch0 count running", 6'd2, 32'd3);
        applyStimulus(1, 0, 0, 0);
        checkOutput("post-reset irq_o", 32'(irq_o), 32'h0);
        checkOutput("post-reset irq", 32'(irq), 32'h0);
        for (int a = 0; a < 20; a++) checkRead($sformatf("post-reset rd@%0d", a), 6'(a), 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit          rst;
            bit          we;
            logic [3:0]  ch;
            logic [1:0]  r;
            logic [31:0] data;
            rst  = ($urandom_range(0, 299) == 0);
            we   = ($urandom_range(0, 2) == 0);
            ch   = 4'($urandom_range(0, 4));
            r    = 2'($urandom_range(0, 3));
            data = $urandom();
            if (r == 2'd0 && $urandom_range(0, 3) != 0) data[15:8] = 8'($urandom_range(0, 3));
            if (r == 2'd1 && $urandom_range(0, 7) != 0) data = 32'($urandom_range(0, 6));
            applyStimulus(rst, we, {ch, r}, data);
            checkOutput($sformatf("rand%0d irq_o", i), 32'(irq_o), 32'(modelIrq()));
            checkOutput($sformatf("rand%0d irq", i), 32'(irq), 32'(|modelIrq()));
            for (int j = 0; j < 3; j++) begin
                logic [5:0] a;
                a = 6'($urandom_range(0, 19));
                checkRead($sformatf("rand%0d rd@%0d", i, a), a, modelRead(a));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
